// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN second-layer datapath blocks.
// Holds the frame sequencer state encoding, default geometry and sum-width helper.
// No logic; imported by the scheduler and its adder stage.
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int Y_DEF     = 8;
  localparam int IMG_W_DEF = 26;
  localparam int IMG_H_DEF = 26;

  // Three signed Y-bit terms need two extra bits to be exact.
  localparam int SUM_GROW  = 2;

  function automatic int sum_w(input int y);
    return y + SUM_GROW;
  endfunction

endpackage

// File: rtl/sum3_reg.sv
// Registered signed three-input adder, Y-bit operands to Y+2-bit result.
// Latency 1 cycle from operands to sum.
// en low holds the registered sum so a stalled output stays stable.
module sum3_reg
  import cnn_pkg::*;
#(
  parameter int Y = Y_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic signed [Y-1:0]       a,
  input  logic signed [Y-1:0]       b,
  input  logic signed [Y-1:0]       c,
  output logic signed [sum_w(Y)-1:0] sum
);

  localparam int SW = sum_w(Y);

  logic signed [SW-1:0] sum_d;
  logic signed [SW-1:0] sum_q;

  // Sign-extend every operand before adding; hold when not enabled.
  always_comb begin
    sum_d = sum_q;
    if (en) begin
      sum_d = SW'(a) + SW'(b) + SW'(c);
    end
  end

  // Result register, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/sum3_sched.sv
// Frame sequencer joining three channel partial-sum streams into tagged three-way sums.
// Latency 2 cycles from input fire to out_valid; 1 pixel/cycle when not stalled.
// out_valid & !out_ready freezes both stages and drops in_ready; nothing is lost.
module sum3_sched
  import cnn_pkg::*;
#(
  parameter int Y     = Y_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = 5,
  parameter int RW    = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic                       ch0_valid,
  input  logic                       ch1_valid,
  input  logic                       ch2_valid,
  input  logic signed [Y-1:0]        ch0_data,
  input  logic signed [Y-1:0]        ch1_data,
  input  logic signed [Y-1:0]        ch2_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [sum_w(Y)-1:0] out_data,
  output logic [CW-1:0]              out_col,
  output logic [RW-1:0]              out_row,
  output logic                       out_last
);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  state_t state_q, state_d;

  // Issue-side coordinate counters.
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Stage 1: operands plus the coordinates they were issued with.
  logic signed [Y-1:0] op0_q, op0_d;
  logic signed [Y-1:0] op1_q, op1_d;
  logic signed [Y-1:0] op2_q, op2_d;
  logic [CW-1:0]       s1_col_q, s1_col_d;
  logic [RW-1:0]       s1_row_q, s1_row_d;
  logic                s1_last_q, s1_last_d;
  logic                s1_valid_q, s1_valid_d;

  // Stage 2: tag bits riding alongside the registered sum.
  logic [CW-1:0]       s2_col_q, s2_col_d;
  logic [RW-1:0]       s2_row_q, s2_row_d;
  logic                s2_last_q, s2_last_d;
  logic                s2_valid_q, s2_valid_d;

  logic stall;
  logic fire;
  logic issue_last;
  logic last_accept;

  assign stall       = s2_valid_q & ~out_ready;
  assign fire        = ch0_valid & ch1_valid & ch2_valid & in_ready;
  assign issue_last  = (col_q == COL_MAX) && (row_q == ROW_MAX);
  assign last_accept = s2_valid_q & s2_last_q & out_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: the last issue moves to DRAIN, the last acceptance ends the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)              state_d = ST_RUN;
      ST_RUN:   if (fire && issue_last) state_d = ST_DRAIN;
      ST_DRAIN: if (last_accept)        state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: input is only accepted in RUN while the output side is moving.
  always_comb begin
    busy     = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        busy     = 1'b1;
        in_ready = ~stall;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        done = last_accept;
      end
      default: ;
    endcase
  end

  // Raster-order coordinate counters; wrapping past the last pixel returns to (0,0).
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (fire) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Stage 1 loads on fire, holds under stall, otherwise empties.
  always_comb begin
    op0_d      = op0_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    s1_col_d   = s1_col_q;
    s1_row_d   = s1_row_q;
    s1_last_d  = s1_last_q;
    s1_valid_d = stall ? s1_valid_q : fire;
    if (fire) begin
      op0_d     = ch0_data;
      op1_d     = ch1_data;
      op2_d     = ch2_data;
      s1_col_d  = col_q;
      s1_row_d  = row_q;
      s1_last_d = issue_last;
    end
  end

  // Stage 2 tags follow stage 1 unless the output is stalled.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_col_d   = s2_col_q;
    s2_row_d   = s2_row_q;
    s2_last_d  = s2_last_q;
    if (!stall) begin
      s2_valid_d = s1_valid_q;
      s2_col_d   = s1_col_q;
      s2_row_d   = s1_row_q;
      s2_last_d  = s1_last_q;
    end
  end

  // All scheduler flops, cleared on reset so a mid-frame reset discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      op0_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      s1_last_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_col_q   <= '0;
      s2_row_q   <= '0;
      s2_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      op0_q      <= op0_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      s1_col_q   <= s1_col_d;
      s1_row_q   <= s1_row_d;
      s1_last_q  <= s1_last_d;
      s1_valid_q <= s1_valid_d;
      s2_col_q   <= s2_col_d;
      s2_row_q   <= s2_row_d;
      s2_last_q  <= s2_last_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // The adder register is frozen with the rest of stage 2 so out_data stays stable under stall.
  sum3_reg #(
    .Y (Y)
  ) u_sum3_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stall),
    .a     (op0_q),
    .b     (op1_q),
    .c     (op2_q),
    .sum   (out_data)
  );

  assign out_valid = s2_valid_q;
  assign out_col   = s2_col_q;
  assign out_row   = s2_row_q;
  assign out_last  = s2_last_q;

endmodule

// File: doc/sum3_sched.md
Name: sum3_sched

Overview:
- Sequences one frame of three-channel partial-sum merging for the CNN second layer.
- Joins three per-channel conv partial-sum streams into operand registers, drives a registered three-input signed adder, and tags each sum with row/col coordinates.
- Presents each result on a valid/ready output stream to the activation/pooling stage.
- Frame-level start/busy/done control is driven by the layer top-level controller.

Parameters:
- Y, 8, width of each signed channel partial sum.
- IMG_W, 26, output columns per frame.
- IMG_H, 26, output rows per frame.
- CW, 5, column counter width; must satisfy 2^CW >= IMG_W.
- RW, 5, row counter width; must satisfy 2^RW >= IMG_H.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame; ignored unless IDLE.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse after the last result is accepted downstream.
- ch0_valid / ch1_valid / ch2_valid  in  1 each  channel data valid.
- ch0_data / ch1_data / ch2_data  in  Y each  signed partial sums.
- in_ready  out  1  shared ready; a transfer fires only when all three valids and in_ready are high.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  Y+2  signed sum.
- out_col  out  CW  column of out_data.
- out_row  out  RW  row of out_data.
- out_last  out  1  high with the final pixel of the frame.

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. On reset, every output is 0, all counters are 0, state is IDLE, and operand and result registers are 0.
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN on the cycle the IMG_W*IMG_H-th pixel fires.
  - DRAIN -> IDLE when the out_last result is accepted. done pulses that same cycle.
- Join:
  - fire = ch0_valid & ch1_valid & ch2_valid & in_ready.
  - in_ready = (state==RUN) & !stall. It may be high while any valid is low; nothing is consumed in that case.
  - Partial channel validity never consumes data. in_ready is 0 in IDLE and DRAIN.
- Pipeline (latency fire -> out_valid = 2 cycles):
  - Stage 1: operand registers and issue-coordinate registers load on fire; s1_valid is set on fire.
  - Stage 2: the adder registers the sum of the stage-1 operands; s2_valid follows s1_valid; out_valid = s2_valid.
- Stall:
  - stall = out_valid & !out_ready.
  - During stall, operand registers, coordinates, and both valid bits hold. The adder recomputes identical operands, so out_data is stable.
  - Without stall, throughput is 1 pixel/cycle.
- Counters:
  - Issue col/row advance on fire. col wraps at IMG_W-1 to 0 and increments row.
  - After the last pixel, counters reset to 0.
  - Coordinates travel with the data through both stages.
- Arithmetic: all three inputs are sign-extended to Y+2 bits. No saturation; the range is exact (-3*2^(Y-1) .. 3*(2^(Y-1)-1)).
- Simultaneous events:
  - start while busy is ignored.
  - A fire in the same cycle as an output accept is legal; the pipeline advances.
  - out_last and done coincide with acceptance of the final pixel; a start in that same cycle is ignored (state is not yet IDLE).
- Reset mid-frame: everything returns to reset values immediately. Partial results are discarded and no done is generated.

Decomposition:
- Shared package `cnn_pkg` holds:
  - the state encoding (IDLE/RUN/DRAIN);
  - default Y, IMG_W, and IMG_H constants;
  - a sum-width helper constant (Y+2).
- One natural sub-module: `sum3_reg`, a registered signed three-input adder (Y in, Y+2 out, async active-low reset to 0, 1-cycle latency), instantiated as stage 2.
- Counters, join logic, and FSM stay in sum3_sched.

Test Plan:
- Basic sum: IMG_W=IMG_H=2, start, then all channels valid with (5,-3,7) -> out_valid 2 cycles after fire, out_data=9, col=0, row=0.
- Extremes, Y=8: (-128,-128,-128) -> -384; (127,127,127) -> 381. No overflow in 10 bits.
- Join: ch1_valid held low for 3 cycles while ch0/ch2 are valid -> no fire and no data consumed; the pixel fires in the cycle ch1_valid rises.
- Backpressure: out_ready low for 4 cycles mid-stream -> out_data/col/row stable, in_ready low, and no pixel lost or duplicated across a 4-pixel frame; order is (0,0),(0,1),(1,0),(1,1).
- Frame end: full 2x2 frame streamed -> out_last only on (1,1); done pulses 1 cycle on its acceptance; busy drops the next cycle; a start during DRAIN is ignored.
- Reset mid-frame: assert rst_n low after 2 fires -> all outputs 0 and state IDLE; a new start runs a complete frame from (0,0).
